instr_fetch: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter. Takes the fetch address presented by the PC and issues it to instruction memory over a valid/ready request channel. Pairs each in-order memory response with its PC and delivers {pc, instr} to decode through a small buffer. Back-pressure stalls the PC; a flush from a taken jump discards all stale work.

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_sync_fifo.sv | 68 ++++++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP           : instruction word presented to decode when nothing is valid
//   fetch_state_e : fetch control states (RUN issues requests, DRAIN drops stale responses)
//   fetch_entry_t : one decoded-bound entry {pc, instr, misalign}
//   is_misaligned : true when a fetch address is not word aligned
package fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory channel between the fetch stage and instruction memory.
//   imem_req_valid / imem_req_ready : request handshake
//   imem_req_addr                   : word-aligned request address
//   imem_rsp_valid / imem_rsp_data  : in-order response, no back-pressure
// master = fetch stage, slave = memory.
interface instr_fetch_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/instr_fetch_sync_fifo.sv
// Small synchronous FIFO with the head entry read straight from registered storage.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous flush of all entries (wins over push/pop)
//   push/push_data, pop : write and read strobes; a push into a full FIFO is
//                         accepted only when a pop frees a slot in the same cycle
//   head       : oldest entry (meaningless while empty)
//   empty, full, count : occupancy, count is $clog2(DEPTH)+1 bits wide
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: forwards the PC to instruction memory, pairs each
// in-order response with its PC and hands {pc, instr, misalign} to decode.
//   ifu_clk, ifu_rst_n          : clock, asynchronous active-low reset
//   ifu_pc, ifu_pc_valid        : fetch address from the PC stage
//   ifu_pc_ready                : address accepted (request handshake fired)
//   ifu_flush                   : jump redirect, kills all in-flight/buffered work
//   imem                        : instruction memory channel (master side)
//   ifu_out_valid/pc/instr/misalign, ifu_out_ready : decode-side handshake
module instr_fetch #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = fetch_pkg::NOP
) (
    input  logic                 ifu_clk,
    input  logic                 ifu_rst_n,
    input  logic [31:0]          ifu_pc,
    input  logic                 ifu_pc_valid,
    output logic                 ifu_pc_ready,
    input  logic                 ifu_flush,
    instr_fetch_if.master        imem,
    output logic                 ifu_out_valid,
    output logic [31:0]          ifu_out_pc,
    output logic [31:0]          ifu_out_instr,
    output logic                 ifu_out_misalign,
    input  logic                 ifu_out_ready
);

    import fetch_pkg::*;

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W  = DEPTH[CW:0];
    localparam logic [0:0]  ST_RUN   = RUN;
    localparam logic [0:0]  ST_DRAIN = DRAIN;

    logic [0:0]    state;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_left;
    logic [CW-1:0] discard_dec;
    logic [CW-1:0] rsp_ext;
    logic [CW:0]   occupancy;
    logic          in_run;
    logic          credit;
    logic          accept;
    logic          rsp_ok;

    logic [32:0]   pend_head;
    logic          pend_pop;
    logic          pend_empty;
    logic          pend_full;
    logic [CW-1:0] pend_count;

    fetch_entry_t  out_head;
    fetch_entry_t  out_entry;
    logic          out_push;
    logic          out_pop;
    logic          out_empty;
    logic          out_full;
    logic [CW-1:0] out_count;

    assign in_run    = (state == ST_RUN);
    assign occupancy = {1'b0, inflight} + {1'b0, out_count};
    assign credit    = occupancy < DEPTH_W;

    // Request path is purely combinational; reset gating keeps the bus quiet
    // while the registers are held in reset.
    assign imem.imem_req_valid = ifu_rst_n & in_run & ifu_pc_valid & credit & ~ifu_flush;
    assign imem.imem_req_addr  = ifu_rst_n ? {ifu_pc[31:2], 2'b00} : 32'h0;
    assign accept              = imem.imem_req_valid & imem.imem_req_ready;
    assign ifu_pc_ready        = accept;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assign rsp_ok       = imem.imem_rsp_valid & (inflight != '0);
    assign rsp_ext      = {{(CW-1){1'b0}}, rsp_ok};
    assign discard_left = inflight - rsp_ext;
    assign discard_dec  = discard - rsp_ext;

    assign pend_pop  = rsp_ok & in_run & ~ifu_flush;
    assign out_push  = pend_pop;
    assign out_entry = '{pc: pend_head[32:1], instr: imem.imem_rsp_data, misalign: pend_head[0]};

    assign ifu_out_valid    = ~out_empty & ~ifu_flush;
    assign out_pop          = ifu_out_valid & ifu_out_ready;
    assign ifu_out_pc       = ifu_out_valid ? out_head.pc : 32'h0;
    assign ifu_out_instr    = ifu_out_valid ? out_head.instr : NOP;
    assign ifu_out_misalign = ifu_out_valid & out_head.misalign;

    sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_pend_fifo (
        .clk       (ifu_clk),
        .rst_n     (ifu_rst_n),
        .clear     (ifu_flush),
        .push      (accept),
        .push_data ({ifu_pc, is_misaligned(ifu_pc)}),
        .pop       (pend_pop),
        .head      (pend_head),
        .empty     (pend_empty),
        .full      (pend_full),
        .count     (pend_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
        .clk       (ifu_clk),
        .rst_n     (ifu_rst_n),
        .clear     (ifu_flush),
        .push      (out_push),
        .push_data (out_entry),
        .pop       (out_pop),
        .head      (out_head),
        .empty     (out_empty),
        .full      (out_full),
        .count     (out_count)
    );

    always_comb begin
        inflight_next = inflight;
        if (accept && !rsp_ok) begin
            inflight_next = inflight + 1'b1;
        end else if (!accept && rsp_ok) begin
            inflight_next = inflight - 1'b1;
        end
    end

    // Flush reloads the discard count with whatever is still outstanding after
    // this cycle's response; DRAIN counts it down and returns to RUN on the
    // edge that drops the last stale response.
    always_ff @(posedge ifu_clk or negedge ifu_rst_n) begin
        if (!ifu_rst_n) begin
            state    <= ST_RUN;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (ifu_flush) begin
                discard <= discard_left;
                state   <= (discard_left != '0) ? ST_DRAIN : ST_RUN;
            end else if (state == ST_DRAIN) begin
                discard <= discard_dec;
                state   <= (discard_dec == '0) ? ST_RUN : ST_DRAIN;
            end
        end
    end

    a_rsp_has_inflight: assert property (@(posedge ifu_clk) disable iff (!ifu_rst_n)
        imem.imem_rsp_valid |-> (inflight != '0));
    a_pend_no_overflow: assert property (@(posedge ifu_clk) disable iff (!ifu_rst_n)
        accept |-> !pend_full);
    a_pend_no_underflow: assert property (@(posedge ifu_clk) disable iff (!ifu_rst_n)
        pend_pop |-> !pend_empty);
    a_out_no_overflow: assert property (@(posedge ifu_clk) disable iff (!ifu_rst_n)
        out_push |-> (!out_full || out_pop));
    a_pend_tracks_inflight: assert property (@(posedge ifu_clk) disable iff (!ifu_rst_n)
        in_run |-> (pend_count == inflight));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch. The bench plays both the PC stage and an
// in-order instruction memory; a queue-based reference model predicts every
// output each cycle.
module tb_instr_fetch;

    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        ifu_clk = 1'b0;
    logic        ifu_rst_n = 1'b1;
    logic [31:0] ifu_pc = 32'h0;
    logic        ifu_pc_valid = 1'b0;
    logic        ifu_pc_ready;
    logic        ifu_flush = 1'b0;
    logic        ifu_out_valid;
    logic [31:0] ifu_out_pc;
    logic [31:0] ifu_out_instr;
    logic        ifu_out_misalign;
    logic        ifu_out_ready = 1'b0;

    instr_fetch_if imem();

    instr_fetch #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .ifu_clk          (ifu_clk),
        .ifu_rst_n        (ifu_rst_n),
        .ifu_pc           (ifu_pc),
        .ifu_pc_valid     (ifu_pc_valid),
        .ifu_pc_ready     (ifu_pc_ready),
        .ifu_flush        (ifu_flush),
        .imem             (imem),
        .ifu_out_valid    (ifu_out_valid),
        .ifu_out_pc       (ifu_out_pc),
        .ifu_out_instr    (ifu_out_instr),
        .ifu_out_misalign (ifu_out_misalign),
        .ifu_out_ready    (ifu_out_ready)
    );

    always #5 ifu_clk = ~ifu_clk;

    // An outstanding request as the memory sees it; dead ones were killed by a flush.
    typedef struct {
        logic [31:0] pc;
        bit          dead;
        int          due;
    } flight_t;

    flight_t      flight_q[$];
    fetch_entry_t buf_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit zero_wait;
    int pv_pct;
    int or_pct;
    int rr_pct;
    int fl_pct;
    bit rand_pc;

    bit exp_req_valid;
    bit exp_accept;
    bit exp_out_valid;

    // Instruction memory contents are a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] random_target();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(3) != 0) begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // All outputs must sit at their reset values while reset is asserted.
    task automatic check_reset();
        check_output("rst_pc_ready", 32'(ifu_pc_ready), 32'h0);
        check_output("rst_req_valid", 32'(imem.imem_req_valid), 32'h0);
        check_output("rst_req_addr", imem.imem_req_addr, 32'h0);
        check_output("rst_out_valid", 32'(ifu_out_valid), 32'h0);
        check_output("rst_out_pc", ifu_out_pc, 32'h0);
        check_output("rst_out_instr", ifu_out_instr, NOP);
        check_output("rst_out_misalign", 32'(ifu_out_misalign), 32'h0);
    endtask

    // Drive this cycle's random inputs, including the memory's response.
    task automatic apply_stimulus();
        imem.imem_req_ready = zero_wait || ($urandom_range(99) < rr_pct);
        ifu_pc_valid        = $urandom_range(99) < pv_pct;
        ifu_out_ready       = $urandom_range(99) < or_pct;
        ifu_flush           = $urandom_range(99) < fl_pct;
        if (flight_q.size() > 0 && flight_q[0].due <= cyc && (zero_wait || $urandom_range(3) != 0)) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word({flight_q[0].pc[31:2], 2'b00});
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
        end
    endtask

    // Predict this cycle's outputs from the model's queues and compare.
    task automatic predict_and_check();
        bit          credit;
        bit          draining;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
        credit        = (flight_q.size() + buf_q.size()) < DEPTH;
        draining      = flight_q.size() > 0 && flight_q[0].dead;
        exp_req_valid = ifu_pc_valid && credit && !draining && !ifu_flush;
        exp_accept    = exp_req_valid && imem.imem_req_ready;
        exp_out_valid = buf_q.size() > 0 && !ifu_flush;
        e_pc    = 32'h0;
        e_instr = NOP;
        e_mis   = 1'b0;
        if (exp_out_valid) begin
            e_pc    = buf_q[0].pc;
            e_instr = buf_q[0].instr;
            e_mis   = buf_q[0].misalign;
        end
        check_output("req_valid", 32'(imem.imem_req_valid), 32'(exp_req_valid));
        check_output("pc_ready", 32'(ifu_pc_ready), 32'(exp_accept));
        check_output("req_addr", imem.imem_req_addr, {ifu_pc[31:2], 2'b00});
        check_output("out_valid", 32'(ifu_out_valid), 32'(exp_out_valid));
        check_output("out_pc", ifu_out_pc, e_pc);
        check_output("out_instr", ifu_out_instr, e_instr);
        check_output("out_misalign", 32'(ifu_out_misalign), 32'(e_mis));
    endtask

    // Advance the model by one clock edge using the inputs that were held.
    task automatic update_model();
        fetch_entry_t e;
        flight_t      f;
        if (ifu_flush) begin
            buf_q.delete();
            if (imem.imem_rsp_valid) begin
                void'(flight_q.pop_front());
            end
            foreach (flight_q[i]) begin
                flight_q[i].dead = 1'b1;
            end
            ifu_pc = rand_pc ? random_target() : 32'h0000_0100;
        end else begin
            if (exp_out_valid && ifu_out_ready) begin
                void'(buf_q.pop_front());
            end
            if (imem.imem_rsp_valid) begin
                f = flight_q.pop_front();
                if (!f.dead) begin
                    e.pc       = f.pc;
                    e.instr    = mem_word({f.pc[31:2], 2'b00});
                    e.misalign = f.pc[1:0] != 2'b00;
                    buf_q.push_back(e);
                end
            end
            if (exp_accept) begin
                f.pc   = ifu_pc;
                f.dead = 1'b0;
                f.due  = cyc + 1 + (zero_wait ? 0 : int'($urandom_range(3)));
                flight_q.push_back(f);
                if (rand_pc && $urandom_range(3) == 0) begin
                    ifu_pc = random_target();
                end else begin
                    ifu_pc = ifu_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_cycle();
        apply_stimulus();
        #2;
        predict_and_check();
        @(posedge ifu_clk);
        #1;
        update_model();
    endtask

    task automatic run_phase(input int n, input bit zw, input int pv, input int orr,
                             input int rr, input int fl, input bit rp, input logic [31:0] start);
        zero_wait = zw;
        pv_pct    = pv;
        or_pct    = orr;
        rr_pct    = rr;
        fl_pct    = fl;
        rand_pc   = rp;
        ifu_pc    = start;
        repeat (n) run_cycle();
    endtask

    // Asynchronous reset in the middle of traffic, then a clean restart.
    task automatic mid_reset();
        ifu_pc              = 32'h0000_0246;
        ifu_pc_valid        = 1'b1;
        ifu_flush           = 1'b0;
        ifu_out_ready       = 1'b1;
        imem.imem_req_ready = 1'b1;
        #1;
        ifu_rst_n           = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        #1;
        check_reset();
        flight_q.delete();
        buf_q.delete();
        @(posedge ifu_clk);
        @(posedge ifu_clk);
        #1;
        ifu_rst_n = 1'b1;
    endtask

    initial begin
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
        ifu_pc              = 32'h0000_1234;
        ifu_pc_valid        = 1'b1;
        #1;
        ifu_rst_n = 1'b0;
        #2;
        check_reset();
        @(posedge ifu_clk);
        @(posedge ifu_clk);
        #1;
        ifu_rst_n = 1'b1;

        run_phase(40, 1'b1, 100, 100, 100, 0, 1'b0, 32'h0000_0000);
        run_phase(30, 1'b1, 100, 20, 100, 0, 1'b0, 32'h0000_0006);
        run_phase(1500, 1'b0, 80, 70, 75, 6, 1'b1, 32'h0000_0100);
        run_phase(6, 1'b0, 100, 0, 100, 0, 1'b0, 32'h0000_0200);
        mid_reset();
        run_phase(500, 1'b0, 85, 60, 80, 8, 1'b1, 32'h0000_0400);
        run_phase(400, 1'b0, 90, 60, 80, 25, 1'b1, 32'h0000_0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
